blink_sequencer: RTL and testbench
==================================

// Module: blink_sequencer
// PURPOSE
//   Sequencing controller for the 4-LED pattern datapath. Owns the step-rate prescaler,
//   the pattern-mode FSM and the run/pause state. Drives MODE/STEP to the downstream
//   LED pattern decoder and emits a one-cycle STEP_EN strobe on every step advance.
//   Mode changes requested while running take effect only at a pattern boundary (wrap).
// PARAMETERS
//   DIV_W   23   prescaler width; base step period = 2**DIV_W cycles (speed 0); must be >= 4
// PORTS
//   CLK      in   1  system clock, all state on posedge
//   RST      in   1  reset, asynchronous, active-high
//   UP       in   1  debounced 1-cycle pulse: request next pattern mode
//   SPD      in   1  debounced 1-cycle pulse: cycle step speed 0->1->2->3->0
//   HOLD     in   1  debounced 1-cycle pulse: toggle RUN/PAUSE
//   MODE     out  2  current pattern: 0 bounce (6 steps), 1 right->left (4), 2 left->right (4)
//   STEP     out  3  current step index, 0..LEN-1 (LEN = 6 for mode 0, else 4)
//   STEP_EN  out  1  high for 1 cycle in the cycle in which a new STEP/MODE value is first visible
//   SPEED    out  2  current speed setting
//   PAUSED   out  1  1 while FSM is in PAUSE
// BEHAVIOUR
//   Reset (async, RST=1): MODE=0, STEP=0, STEP_EN=0, SPEED=0, PAUSED=0, FSM=RUN,
//     pending=0, prescaler cnt=0. All outputs registered.
//   Prescaler: DIV_W-bit free-running cnt, +1 per cycle, wraps. tick = low (DIV_W-SPEED) bits
//     of cnt all ones -> step period 2**(DIV_W-SPEED) cycles. SPD pulse: SPEED+1 (wrap 3->0),
//     cnt cleared to 0 the next cycle; no tick in the SPD cycle.
//   FSM RUN:
//     - tick && STEP<LEN-1: STEP+1, STEP_EN=1 next cycle.
//     - tick && STEP==LEN-1 (wrap): STEP=0, STEP_EN=1; if (pending|UP) then MODE advances
//       (2->0) and pending cleared in the same update.
//     - UP without wrap tick: pending=1. UP while pending already 1: ignored (no queueing).
//     - HOLD: -> PAUSE next cycle, PAUSED=1. UP in the same cycle sets pending first.
//   FSM PAUSE:
//     - ticks ignored; STEP, MODE frozen; STEP_EN=0; prescaler keeps counting.
//     - pending=1 on entry: applied on the first PAUSE cycle: MODE+1, STEP=0, pending=0, STEP_EN=1.
//     - UP: MODE+1 (2->0), STEP=0, STEP_EN=1 next cycle.
//     - HOLD: -> RUN, PAUSED=0, cnt cleared to 0 so first step after resume is a full period.
//       UP in the same cycle is applied with PAUSE rules (immediate).
//   MODE value 3 never produced; if ever present, treated as 0 on next update.
//   SPD is honoured in both states; SPD+tick same cycle: tick dropped.
//   STEP always < LEN of the current MODE (mode change always forces STEP=0).
// TESTING (DIV_W=4: periods 16/8/4/2 cycles)
//   1. Release reset, run 112 cycles -> STEP 1,2,3,4,5,0,1 with STEP_EN every 16 cycles,
//      first STEP_EN 16 cycles after reset release; MODE=0 throughout.
//   2. MODE=0, UP pulse at STEP=2, 2nd UP at STEP=3 -> MODE stays 0 through STEP 5,
//      then MODE=1, STEP=0 at wrap; MODE never reaches 2 (2nd UP dropped).
//   3. UP coincident with wrap tick in mode 2 -> MODE=0, STEP=0 in that same update.
//   4. HOLD -> PAUSED=1, STEP constant 100 cycles, no STEP_EN; UP -> MODE+1, STEP=0, one
//      STEP_EN; HOLD -> PAUSED=0, next STEP_EN exactly 16 cycles after resume.
//   5. SPD once -> STEP_EN period 8, SPEED=1; SPD x3 more -> SPEED=0, period 16.
//   6. Assert RST between clock edges mid-run (MODE=1, STEP=2, pending=1) -> all outputs
//      at reset values before next posedge; after release, behaves as test 1.

Source files
------------

// File: rtl/blink_sequencer.sv
// Sequencing controller for the 4-LED pattern datapath: step-rate prescaler,
// pattern-mode FSM with run/pause, and a one-cycle strobe on every step update.
module blink_sequencer #(
    parameter int DIV_W = 23
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       UP,
    input  logic       SPD,
    input  logic       HOLD,
    output logic [1:0] MODE,
    output logic [2:0] STEP,
    output logic       STEP_EN,
    output logic [1:0] SPEED,
    output logic       PAUSED
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_PAUSE = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] cnt_s;
    logic [DIV_W-1:0] mask_s;
    logic [1:0]       mode_r;
    logic [1:0]       mode_s;
    logic [1:0]       mode_eff_s;
    logic [1:0]       mode_adv_s;
    logic [1:0]       speed_r;
    logic [1:0]       speed_s;
    logic [2:0]       step_r;
    logic [2:0]       step_s;
    logic [2:0]       last_s;
    logic             step_en_r;
    logic             step_en_s;
    logic             pending_r;
    logic             pending_s;
    logic             tick_s;

    // Prescaler tick and mode helpers; an illegal mode 3 behaves as mode 0.
    always_comb begin
        mask_s     = {DIV_W{1'b1}} >> speed_r;
        tick_s     = ((cnt_r & mask_s) == mask_s) && !SPD;
        mode_eff_s = (mode_r == 2'd3) ? 2'd0 : mode_r;
        last_s     = ((mode_r == 2'd1) || (mode_r == 2'd2)) ? 3'd3 : 3'd5;
        case (mode_r)
            2'd0:    mode_adv_s = 2'd1;
            2'd1:    mode_adv_s = 2'd2;
            2'd3:    mode_adv_s = 2'd1;
            default: mode_adv_s = 2'd0;
        endcase
    end

    // Next-state logic for FSM, step/mode, pending request, speed and prescaler.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r + DIV_W'(1);
        speed_s   = speed_r;
        mode_s    = mode_r;
        step_s    = step_r;
        step_en_s = 1'b0;
        pending_s = pending_r;

        if (SPD) begin
            speed_s = speed_r + 2'd1;
            cnt_s   = '0;
        end else begin
            speed_s = speed_r;
        end

        case (state_r)
            ST_RUN: begin
                if (tick_s) begin
                    step_en_s = 1'b1;
                    mode_s    = mode_eff_s;
                    if (step_r >= last_s) begin
                        step_s = 3'd0;
                        // Queued or coincident request is applied exactly at the wrap.
                        if (pending_r || UP) begin
                            mode_s    = mode_adv_s;
                            pending_s = 1'b0;
                        end else begin
                            pending_s = pending_r;
                        end
                    end else begin
                        step_s = step_r + 3'd1;
                        if (UP) begin
                            pending_s = 1'b1;
                        end else begin
                            pending_s = pending_r;
                        end
                    end
                end else if (UP) begin
                    pending_s = 1'b1;
                end else begin
                    pending_s = pending_r;
                end
                if (HOLD) begin
                    state_s = ST_PAUSE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (pending_r || UP) begin
                    mode_s    = mode_adv_s;
                    step_s    = 3'd0;
                    step_en_s = 1'b1;
                    pending_s = 1'b0;
                end else begin
                    pending_s = pending_r;
                end
                // Restart the prescaler so the first step after resume is a full period.
                if (HOLD) begin
                    state_s = ST_RUN;
                    cnt_s   = '0;
                end else begin
                    state_s = ST_PAUSE;
                end
            end
            default: begin
                state_s = ST_RUN;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r   <= ST_RUN;
            cnt_r     <= '0;
            speed_r   <= 2'd0;
            mode_r    <= 2'd0;
            step_r    <= 3'd0;
            step_en_r <= 1'b0;
            pending_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            speed_r   <= speed_s;
            mode_r    <= mode_s;
            step_r    <= step_s;
            step_en_r <= step_en_s;
            pending_r <= pending_s;
        end
    end

    assign MODE    = mode_r;
    assign STEP    = step_r;
    assign STEP_EN = step_en_r;
    assign SPEED   = speed_r;
    assign PAUSED  = (state_r == ST_PAUSE);

endmodule

// File: tb/tb_blink_sequencer.sv
// Directed self-checking bench for blink_sequencer with DIV_W=4
// (step periods 16/8/4/2 cycles).
module tb_blink_sequencer;

    logic       CLK;
    logic       RST;
    logic       UP;
    logic       SPD;
    logic       HOLD;
    logic [1:0] MODE;
    logic [2:0] STEP;
    logic       STEP_EN;
    logic [1:0] SPEED;
    logic       PAUSED;

    int total_cnt;
    int bad_cnt;

    blink_sequencer #(.DIV_W(4)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .UP      (UP),
        .SPD     (SPD),
        .HOLD    (HOLD),
        .MODE    (MODE),
        .STEP    (STEP),
        .STEP_EN (STEP_EN),
        .SPEED   (SPEED),
        .PAUSED  (PAUSED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int got, input int exp);
        total_cnt++;
        if (got != exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Count cycles until STEP_EN is seen high (bounded).
    task automatic wait_en(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!STEP_EN && n < 100);
    endtask

    task automatic pulse_up();
        UP = 1'b1;
        cyc();
        UP = 1'b0;
    endtask

    task automatic pulse_hold();
        HOLD = 1'b1;
        cyc();
        HOLD = 1'b0;
    endtask

    task automatic pulse_spd();
        SPD = 1'b1;
        cyc();
        SPD = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " mode"},   int'(MODE), 0);
        check({tag, " step"},   int'(STEP), 0);
        check({tag, " en"},     int'(STEP_EN), 0);
        check({tag, " speed"},  int'(SPEED), 0);
        check({tag, " paused"}, int'(PAUSED), 0);
    endtask

    // Seven full-period steps from a fresh reset, mode 0 throughout.
    task automatic run_from_reset(input string tag);
        int n;
        int exp_step [7] = '{1, 2, 3, 4, 5, 0, 1};
        for (int i = 0; i < 7; i++) begin
            wait_en(n);
            check({tag, " period"}, n, 16);
            check({tag, " step"}, int'(STEP), exp_step[i]);
            check({tag, " mode"}, int'(MODE), 0);
        end
    endtask

    initial begin
        int n;
        int en_seen;
        int step_bad;
        total_cnt = 0;
        bad_cnt   = 0;
        RST  = 1'b1;
        UP   = 1'b0;
        SPD  = 1'b0;
        HOLD = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_vals("rst");
        RST = 1'b0;

        // Test 1: free run at speed 0.
        run_from_reset("t1");

        // Test 2: UP at STEP=2 queues; second UP at STEP=3 is dropped.
        wait_en(n);
        check("t2 step2", int'(STEP), 2);
        pulse_up();
        wait_en(n);
        check("t2 step3", int'(STEP), 3);
        pulse_up();
        wait_en(n);
        check("t2 step4", int'(STEP), 4);
        check("t2 mode4", int'(MODE), 0);
        wait_en(n);
        check("t2 step5", int'(STEP), 5);
        check("t2 mode5", int'(MODE), 0);
        wait_en(n);
        check("t2 wrap step", int'(STEP), 0);
        check("t2 wrap mode", int'(MODE), 1);
        for (int i = 1; i <= 4; i++) begin
            wait_en(n);
            check("t2 m1 step", int'(STEP), i % 4);
            check("t2 m1 mode", int'(MODE), 1);
        end

        // Test 3: reach mode 2, then UP coincident with the wrap tick.
        pulse_up();
        for (int i = 1; i <= 4; i++) begin
            wait_en(n);
        end
        check("t3 m2 mode", int'(MODE), 2);
        check("t3 m2 step", int'(STEP), 0);
        for (int i = 1; i <= 3; i++) begin
            wait_en(n);
        end
        check("t3 last step", int'(STEP), 3);
        repeat (15) cyc();
        check("t3 no early en", int'(STEP_EN), 0);
        pulse_up();
        check("t3 en", int'(STEP_EN), 1);
        check("t3 mode", int'(MODE), 0);
        check("t3 step", int'(STEP), 0);

        // Test 4: pause, UP while paused, resume with a full period.
        wait_en(n);
        check("t4 pre step", int'(STEP), 1);
        pulse_hold();
        check("t4 paused", int'(PAUSED), 1);
        en_seen  = 0;
        step_bad = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (STEP_EN) en_seen++;
            if (STEP != 3'd1) step_bad++;
        end
        check("t4 frozen en", en_seen, 0);
        check("t4 frozen step", step_bad, 0);
        pulse_up();
        check("t4 up en", int'(STEP_EN), 1);
        check("t4 up mode", int'(MODE), 1);
        check("t4 up step", int'(STEP), 0);
        cyc();
        check("t4 up en once", int'(STEP_EN), 0);
        pulse_hold();
        check("t4 resumed", int'(PAUSED), 0);
        wait_en(n);
        check("t4 resume period", n, 16);
        check("t4 resume step", int'(STEP), 1);

        // Test 5: speed 1 halves the period; three more SPD pulses wrap to 0.
        pulse_spd();
        check("t5 speed1", int'(SPEED), 1);
        wait_en(n);
        check("t5 period8a", n, 8);
        wait_en(n);
        check("t5 period8b", n, 8);
        check("t5 step", int'(STEP), 3);
        pulse_spd();
        pulse_spd();
        pulse_spd();
        check("t5 speed0", int'(SPEED), 0);
        wait_en(n);
        check("t5 period16a", n, 16);
        check("t5 wrap step", int'(STEP), 0);
        wait_en(n);
        check("t5 period16b", n, 16);

        // Test 6: async reset mid-run with a request pending.
        wait_en(n);
        pulse_up();
        check("t6 pre mode", int'(MODE), 1);
        check("t6 pre step", int'(STEP), 2);
        #2;
        RST = 1'b1;
        #1;
        check_reset_vals("t6 async");
        @(posedge CLK);
        #1;
        RST = 1'b0;
        run_from_reset("t6 rerun");

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
